dcache_controller: RTL and testbench

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

---
 rtl/dcache_pkg.sv | 15 +
 rtl/dcache_sram.sv | 59 +++++
 rtl/dcache_controller.sv | 167 ++++++++++++++++
 tb/tb_dcache_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths and FSM state type for the data cache controller
// Contents: default line geometry (LINE_BITS, OFF_W, IDX_W, TAG_W) and the
// controller state enum (IDLE, WRITEBACK, ALLOCATE). No ports.
package dcache_pkg;
  localparam int LINE_BITS = 128;
  localparam int OFF_W     = 4;
  localparam int IDX_W     = 4;
  localparam int TAG_W     = 32 - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;
endpackage

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - tag/valid/dirty/data arrays of the direct-mapped data cache
// Ports:
//   clk_i                 clock, all writes on its rising edge
//   clr_valid_i           clears every valid and dirty bit (tag/data untouched)
//   rd_idx_i              combinational read index
//   rd_tag_o/rd_valid_o/rd_dirty_o/rd_data_o  contents of line rd_idx_i
//   wr_en_i               write one whole line, its tag, valid=1 and wr_dirty_i
//   wr_idx_i/wr_tag_i/wr_data_i/wr_dirty_i    write payload
module dcache_sram #(
  parameter int NUM_LINES = 16,
  parameter int DATA_W    = 128,
  parameter int IW        = 4,
  parameter int TW        = 24
) (
  input  logic              clk_i,
  input  logic              clr_valid_i,
  input  logic [IW-1:0]     rd_idx_i,
  output logic [TW-1:0]     rd_tag_o,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IW-1:0]     wr_idx_i,
  input  logic [TW-1:0]     wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_dirty_i
);
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TW-1:0]        tag_q  [NUM_LINES];
  logic [DATA_W-1:0]    data_q [NUM_LINES];

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (clr_valid_i) begin
      valid_d = '0;
      dirty_d = '0;
    end else if (wr_en_i) begin
      valid_d[wr_idx_i] = 1'b1;
      dirty_d[wr_idx_i] = wr_dirty_i;
    end
  end

  always_ff @(posedge clk_i) begin
    valid_q <= valid_d;
    dirty_q <= dirty_d;
    // Tag and data are plain storage: only the valid bit says whether they mean anything.
    if (wr_en_i && !clr_valid_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end
endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back, write-allocate data cache controller
// Ports:
//   clk_i, rst_i (sync, active-low)
//   cpu_req_i/cpu_we_i/cpu_addr_i/cpu_data_i  MEM-stage access, held while stalled
//   cpu_data_o   load data on a hit, 0 otherwise
//   cpu_stall_o  pipeline freeze, combinational on a miss, held until the lookup hits
//   mem_req_o/mem_we_o/mem_addr_o/mem_data_o  line write-back or fetch, held until mem_ack_i
//   mem_data_i/mem_ack_i                       fetched line and one-cycle completion pulse
module dcache_controller #(
  parameter int NUM_LINES = 16,
  parameter int LINE_BITS = dcache_pkg::LINE_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);
  import dcache_pkg::*;

  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 32 - IW - OFF_W;

  logic [IW-1:0]        req_idx;
  logic [TW-1:0]        req_tag;
  logic [1:0]           word_sel;
  logic                 unused_byte_bits;

  logic [TW-1:0]        rd_tag;
  logic                 rd_valid;
  logic                 rd_dirty;
  logic [LINE_BITS-1:0] rd_data;

  logic                 lookup_en;
  logic                 hit;
  logic                 miss;
  logic                 fill;
  logic                 wr_en;
  logic                 wr_dirty;
  logic [LINE_BITS-1:0] wr_data;
  logic [LINE_BITS-1:0] merged;
  logic [31:0]          rd_word;

  state_e               state_q, state_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0] mem_data_q, mem_data_d;

  assign req_idx          = cpu_addr_i[OFF_W +: IW];
  assign req_tag          = cpu_addr_i[31 -: TW];
  assign word_sel         = cpu_addr_i[3:2];
  assign unused_byte_bits = ^cpu_addr_i[1:0];

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .DATA_W    (LINE_BITS),
    .IW        (IW),
    .TW        (TW)
  ) u_sram (
    .clk_i       (clk_i),
    .clr_valid_i (~rst_i),
    .rd_idx_i    (req_idx),
    .rd_tag_o    (rd_tag),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_data_o   (rd_data),
    .wr_en_i     (wr_en),
    .wr_idx_i    (req_idx),
    .wr_tag_i    (req_tag),
    .wr_data_i   (wr_data),
    .wr_dirty_i  (wr_dirty)
  );

  // Lookup, word select/merge and the array write port.
  always_comb begin
    lookup_en = rst_i & (state_q == IDLE);
    hit       = cpu_req_i & rd_valid & (rd_tag == req_tag);
    miss      = lookup_en & cpu_req_i & ~hit;
    rd_word   = rd_data[{word_sel, 5'b0} +: 32];
    merged    = rd_data;
    merged[{word_sel, 5'b0} +: 32] = cpu_data_i;
    // The CPU holds its address during the miss, so the fill lands on req_idx/req_tag.
    fill      = rst_i & (state_q == ALLOCATE) & mem_ack_i;
    wr_en     = (lookup_en & hit & cpu_we_i) | fill;
    wr_data   = fill ? mem_data_i : merged;
    wr_dirty  = ~fill;
  end

  assign cpu_stall_o = rst_i & ((state_q != IDLE) | miss);
  assign cpu_data_o  = (lookup_en & hit & ~cpu_we_i) ? rd_word : 32'h0;
  // Gated so the memory side is quiet in the reset cycle itself, not just after it.
  assign mem_req_o   = mem_req_q & rst_i;
  assign mem_we_o    = mem_we_q & rst_i;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    case (state_q)
      IDLE: begin
        if (miss) begin
          mem_req_d = 1'b1;
          if (rd_valid && rd_dirty) begin
            state_d    = WRITEBACK;
            mem_we_d   = 1'b1;
            mem_addr_d = {rd_tag, req_idx, {OFF_W{1'b0}}};
            mem_data_d = rd_data;
          end else begin
            state_d    = ALLOCATE;
            mem_we_d   = 1'b0;
            mem_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
          end
        end
      end
      WRITEBACK: begin
        // Request stays up across the hand-over so the fetch follows without a gap.
        if (mem_ack_i) begin
          state_d    = ALLOCATE;
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
        end
      end
      ALLOCATE: begin
        if (mem_ack_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 32'h0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - scoreboard bench for dcache_controller
module tb_dcache_controller;
  localparam int LAT = 3;

  logic         clk_i;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_data_o;
  logic [127:0] mem_data_i;
  logic         mem_ack_i;

  dcache_controller #(.NUM_LINES(16), .LINE_BITS(128)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    int          stall;
    int          req;
    int          we;
    int          chg;
  } cpu_exp_t;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] data;
  } mem_exp_t;

  cpu_exp_t     cpu_q [$];
  mem_exp_t     mem_q [$];
  logic         m_valid [16];
  logic         m_dirty [16];
  logic [23:0]  m_tag   [16];
  logic [127:0] m_data  [16];
  logic [127:0] mem_img [logic [31:0]];
  int           wait_cnt;
  int           hold_cnt;
  int           n_tests;
  int           n_fail;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fetch(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a ^ 32'hC0DE_0003, a ^ 32'hC0DE_0002, a ^ 32'hC0DE_0001, a ^ 32'hC0DE_0000};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // Reference cache: pushes the expected memory transactions and CPU-visible result.
  task automatic predict(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    cpu_exp_t    e;
    mem_exp_t    m;
    logic [3:0]  idx;
    logic [23:0] tag;
    logic [31:0] line;
    logic [1:0]  w;
    logic        vd;
    idx  = addr[7:4];
    tag  = addr[31:8];
    line = {addr[31:4], 4'h0};
    w    = addr[3:2];
    e    = '{data: 32'h0, stall: 0, req: 0, we: 0, chg: 0};
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      vd = m_valid[idx] && m_dirty[idx];
      if (vd) begin
        m.we   = 1'b1;
        m.addr = {m_tag[idx], idx, 4'h0};
        m.data = m_data[idx];
        mem_q.push_back(m);
        mem_img[m.addr] = m_data[idx];
      end
      m.we   = 1'b0;
      m.addr = line;
      m.data = '0;
      mem_q.push_back(m);
      m_data[idx]  = fetch(line);
      m_tag[idx]   = tag;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      e.stall = vd ? 1 + 2 * (LAT + 1) + hold : 2 + LAT + hold;
      e.req   = e.stall - 1;
      e.we    = vd ? LAT + 1 + hold : 0;
      e.chg   = vd ? 1 : 0;
    end
    if (we) begin
      m_data[idx][{w, 5'b0} +: 32] = wdata;
      m_dirty[idx] = 1'b1;
    end else begin
      e.data = m_data[idx][{w, 5'b0} +: 32];
    end
    cpu_q.push_back(e);
  endtask

  // Memory responder: after hold_cnt extra cycles, waits LAT cycles then pulses ack.
  task automatic mem_model();
    mem_exp_t e;
    if (mem_ack_i) begin
      mem_ack_i = 1'b0;
      wait_cnt  = 0;
    end
    if (mem_req_o) begin
      if (hold_cnt > 0) hold_cnt--;
      else if (wait_cnt < LAT) wait_cnt++;
      else begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem_we_o ? 128'h0 : fetch(mem_addr_o);
        check_eq("mem_txn_expected", 128'(mem_q.size() != 0), 128'(1));
        if (mem_q.size() != 0) begin
          e = mem_q.pop_front();
          check_eq($sformatf("mem_we@%0h", e.addr), 128'(mem_we_o), 128'(e.we));
          check_eq("mem_addr", 128'(mem_addr_o), 128'(e.addr));
          if (e.we) check_eq($sformatf("wb_data@%0h", e.addr), mem_data_o, e.data);
        end
      end
    end
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    cpu_exp_t    e;
    logic        done;
    logic [31:0] data;
    logic [31:0] prev;
    int          st, rq, wn, ch;
    predict(we, addr, wdata, hold);
    hold_cnt = hold;
    done = 1'b0; data = 32'h0; prev = 32'h0;
    st = 0; rq = 0; wn = 0; ch = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk_i); #1;
      cpu_req_i  = 1'b1;
      cpu_we_i   = we;
      cpu_addr_i = addr;
      cpu_data_i = wdata;
      mem_model();
      @(negedge clk_i);
      if (mem_req_o) begin
        if (rq > 0 && mem_addr_o !== prev) ch++;
        prev = mem_addr_o;
        rq++;
      end
      if (mem_we_o) wn++;
      if (!cpu_stall_o) begin
        done = 1'b1;
        data = cpu_data_o;
      end else st++;
    end
    check_eq($sformatf("done@%0h", addr), 128'(done), 128'(1));
    e = cpu_q.pop_front();
    check_eq($sformatf("data@%0h", addr), 128'(data), 128'(e.data));
    check_eq($sformatf("stall_cycles@%0h", addr), 128'(st), 128'(e.stall));
    check_eq($sformatf("req_cycles@%0h", addr), 128'(rq), 128'(e.req));
    check_eq($sformatf("we_cycles@%0h", addr), 128'(wn), 128'(e.we));
    check_eq($sformatf("addr_changes@%0h", addr), 128'(ch), 128'(e.chg));
  endtask

  task automatic idle_cycle(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk_i); #1;
    cpu_req_i  = 1'b0;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_data_i = wdata;
    mem_model();
    @(negedge clk_i);
    check_eq("idle_stall", 128'(cpu_stall_o), 128'(0));
    check_eq("idle_data", 128'(cpu_data_o), 128'(0));
    check_eq("idle_mem_req", 128'(mem_req_o), 128'(0));
  endtask

  initial begin
    n_tests = 0; n_fail = 0; wait_cnt = 0; hold_cnt = 0;
    rst_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    cpu_addr_i = 32'h0; cpu_data_i = 32'h0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    model_reset();
    mem_img[32'h40] = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_mem_req", 128'(mem_req_o), 128'(0));
    check_eq("rst_mem_we", 128'(mem_we_o), 128'(0));
    check_eq("rst_stall", 128'(cpu_stall_o), 128'(0));
    check_eq("rst_data", 128'(cpu_data_o), 128'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check_eq("post_rst_mem_req", 128'(mem_req_o), 128'(0));
    check_eq("post_rst_stall", 128'(cpu_stall_o), 128'(0));

    access(1'b0, 32'h0000_0040, 32'h0, 0);          // clean miss, 5 stall cycles
    access(1'b0, 32'h0000_0044, 32'h0, 0);          // hit
    access(1'b1, 32'h0000_0048, 32'hDEAD_BEEF, 0);  // store hit, line 4 dirty
    access(1'b0, 32'h0000_0048, 32'h0, 0);
    idle_cycle(1'b1, 32'h0000_0048, 32'h1234_5678); // no request: must not write
    idle_cycle(1'b0, 32'h0000_0000, 32'h0);
    access(1'b0, 32'h0000_0048, 32'h0, 0);
    access(1'b0, 32'h0000_1048, 32'h0, 0);          // dirty miss: write-back then fetch
    access(1'b1, 32'h0000_0080, 32'hCAFE_F00D, 0);  // store miss, write-allocate
    access(1'b0, 32'h0000_0080, 32'h0, 0);
    access(1'b0, 32'h0000_1080, 32'h0, 0);          // evicts merged line 8
    access(1'b0, 32'h0000_0000, 32'h0, 0);          // index 0 cold miss

    // Reset while a fetch is outstanding, then a late ack.
    hold_cnt = 1000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0040; cpu_data_i = 32'h0;
      mem_model();
      @(negedge clk_i);
    end
    check_eq("alloc_req", 128'(mem_req_o), 128'(1));
    check_eq("alloc_we", 128'(mem_we_o), 128'(0));
    check_eq("alloc_addr", 128'(mem_addr_o), 128'(32'h40));
    check_eq("alloc_stall", 128'(cpu_stall_o), 128'(1));
    @(posedge clk_i); #1;
    rst_i = 1'b0; cpu_req_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst_alloc_mem_req", 128'(mem_req_o), 128'(0));
    check_eq("rst_alloc_stall", 128'(cpu_stall_o), 128'(0));
    check_eq("rst_alloc_data", 128'(cpu_data_o), 128'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b1; mem_ack_i = 1'b1; mem_data_i = {128{1'b1}};
    @(negedge clk_i);
    check_eq("late_ack_mem_req", 128'(mem_req_o), 128'(0));
    check_eq("late_ack_stall", 128'(cpu_stall_o), 128'(0));
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    check_eq("after_ack_mem_req", 128'(mem_req_o), 128'(0));
    model_reset();
    hold_cnt = 0; wait_cnt = 0;
    access(1'b0, 32'h0000_0040, 32'h0, 0);          // must miss again
    access(1'b0, 32'h0000_0080, 32'h0, 0);          // must miss again

    // Long write-back stall: ack withheld for 20 cycles.
    access(1'b1, 32'h0000_0040, 32'h5555_AAAA, 0);
    access(1'b0, 32'h0000_2040, 32'h0, 20);
    access(1'b0, 32'h0000_0040, 32'h0, 0);          // clean miss back to the written line
    idle_cycle(1'b0, 32'h0, 32'h0);

    check_eq("cpu_q_drained", 128'(cpu_q.size()), 128'(0));
    check_eq("mem_q_drained", 128'(mem_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
